// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width default and transmit sequencer state encoding
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic {IDLE, WAIT} seq_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular FIFO with explicit occupancy count; writes while full and reads while empty are ignored
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic push, pop;
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign rd_data = mem[rptr];
  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wr_data;
  // pointers wrap naturally at DEPTH; count absorbs simultaneous push and pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(push);
      rptr  <= rptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: host byte FIFO feeding a UART one frame at a time; UART_TX_FIFO_OVF_EN enables the sticky overflow flag
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_done
);
  seq_state_e state, state_n;
  logic pop;
  logic [DATA_W-1:0] rd_data;
  uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
  // launch from IDLE whenever a byte is queued; WAIT holds until the UART reports frame end
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    pop     = state == IDLE && !empty;
    state_n = state == IDLE ? (empty ? IDLE : WAIT) : (tx_done ? IDLE : WAIT);
  end
  // state, launch pulse and presented byte are all registered so no input reaches an output combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_n;
      tx_start <= pop;
      if (pop) tx_data <= rd_data;
    end
`ifdef UART_TX_FIFO_OVF_EN
  // sticky record of any write dropped because the FIFO was full
  always_ff @(posedge clk or posedge rst)
    if (rst) overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with the UART frame-end pulse driven by hand
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0;
  logic tx_done = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, overflow, tx_start;
  logic [4:0] count;
  logic [7:0] tx_data;
  int checks = 0;
  int failures = 0;
  int peak = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    if (int'(count) > peak) peak = int'(count);
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick;
    wr_en = 1'b0;
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_empty_fall got=%b exp=0", empty); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_start_early got=%b exp=0", tx_start); end
    tick;
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", tx_data); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty_after_pop got=%b exp=1", empty); end
    tick;
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b exp=0", tx_start); end
    tick;
    tick;
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_wait_hold got=%b exp=0", tx_start); end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    tick;
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_no_relaunch got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data_held got=%h exp=a5", tx_data); end
  endtask

  task automatic test_burst;
    logic [7:0] b [10];
    b = '{8'd12, 8'd45, 8'd200, 8'd10, 8'd99, 8'd150, 8'd77, 8'd31, 8'd188, 8'd64};
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = b[i];
      tick;
      if (i == 1) begin
        checks++; if (tx_start !== 1'b1 || tx_data !== b[0]) begin failures++; $display("FAIL burst_first start=%b data=%h exp start=1 data=%h", tx_start, tx_data, b[0]); end
      end
    end
    wr_en = 1'b0;
    checks++; if (peak !== 9) begin failures++; $display("FAIL burst_peak got=%0d exp=9", peak); end
    for (int k = 1; k < 10; k++) begin
      tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL burst_gap_%0d got=%b exp=0", k, tx_start); end
      tick;
      checks++; if (tx_start !== 1'b1 || tx_data !== b[k]) begin failures++; $display("FAIL burst_launch_%0d start=%b data=%h exp start=1 data=%h", k, tx_start, tx_data, b[k]); end
    end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    tick;
    tick;
    checks++; if (tx_start !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL burst_drained start=%b empty=%b count=%0d exp 0 1 0", tx_start, empty, count); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i);
      tick;
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
    checks++; if (tx_data !== 8'h30) begin failures++; $display("FAIL fill_in_flight got=%h exp=30", tx_data); end
    checks++; if (overflow !== OVF_EXP) begin failures++; $display("FAIL fill_overflow got=%b exp=%b", overflow, OVF_EXP); end
    for (int k = 1; k <= DEPTH; k++) begin
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      tick;
      checks++; if (tx_start !== 1'b1 || tx_data !== 8'(8'h30 + k)) begin failures++; $display("FAIL fill_drain_%0d start=%b data=%h exp start=1 data=%h", k, tx_start, tx_data, 8'(8'h30 + k)); end
    end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    tick;
    tick;
    checks++; if (empty !== 1'b1 || tx_start !== 1'b0 || tx_data !== 8'h40) begin failures++; $display("FAIL fill_last_dropped empty=%b start=%b data=%h exp 1 0 40", empty, tx_start, tx_data); end
  endtask

  task automatic test_wrap;
    int sent;
    int rcv;
    logic pend;
    sent = 0; rcv = 0; pend = 1'b0; peak = 0;
    for (int c = 0; c < 400 && rcv < 40; c++) begin
      wr_en = (sent < 40) && (c % 3 != 2);
      wr_data = 8'(sent * 7 + 3);
      tx_done = pend;
      tick;
      if (wr_en) sent++;
      pend = 1'b0;
      if (tx_start) begin
        checks++; if (tx_data !== 8'(rcv * 7 + 3)) begin failures++; $display("FAIL wrap_byte_%0d got=%h exp=%h", rcv, tx_data, 8'(rcv * 7 + 3)); end
        rcv++;
        pend = 1'b1;
      end
    end
    wr_en = 1'b0;
    tx_done = pend;
    tick;
    tx_done = 1'b0;
    tick;
    checks++; if (rcv !== 40) begin failures++; $display("FAIL wrap_received got=%0d exp=40", rcv); end
    checks++; if (peak > DEPTH) begin failures++; $display("FAIL wrap_peak got=%0d exp<=16", peak); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_simul;
    wr_en = 1'b1; wr_data = 8'h11; tick;
    wr_data = 8'h22; tick;
    wr_data = 8'h33; tick;
    wr_data = 8'h44; tick;
    wr_en = 1'b0;
    checks++; if (count !== 5'd3 || tx_data !== 8'h11) begin failures++; $display("FAIL simul_setup count=%0d data=%h exp 3 11", count, tx_data); end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    wr_en = 1'b1; wr_data = 8'h55;
    tick;
    wr_en = 1'b0;
    checks++; if (count !== 5'd3) begin failures++; $display("FAIL simul_count got=%0d exp=3", count); end
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h22) begin failures++; $display("FAIL simul_launch start=%b data=%h exp 1 22", tx_start, tx_data); end
    wr_en = 1'b1; wr_data = 8'h66; tick;
    wr_data = 8'h77; tick;
    wr_en = 1'b0;
    checks++; if (count !== 5'd5) begin failures++; $display("FAIL simul_count5 got=%0d exp=5", count); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL rstmid_count count=%0d empty=%b exp 0 1", count, empty); end
    checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx start=%b data=%h exp 0 00", tx_start, tx_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (tx_start !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_launch got=%b exp=0", seen); end
    wr_en = 1'b1; wr_data = 8'h99;
    tick;
    wr_en = 1'b0;
    tick;
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h99) begin failures++; $display("FAIL rstmid_relaunch start=%b data=%h exp 1 99", tx_start, tx_data); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_fill;
    test_wrap;
    test_simul;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer and frame sequencer that sits directly upstream of the `uart` transmitter. It accepts bytes from a host write port into a circular FIFO and feeds the UART one byte at a time: it presents `tx_data`, pulses `tx_start`, then waits for the UART's `txdone` before launching the next frame. This lets the host burst-write a message without tracking UART frame timing.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `DATA_W`, 8: byte width; must match the UART `txin` width.
- `clk` in 1: system clock; the same clock as `uart`.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: host write strobe; one byte per cycle.
- `wr_data` in DATA_W: host byte.
- `full` out 1: FIFO holds DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag set by a write while full (see Configuration).
- `tx_start` out 1: one-cycle frame-launch pulse to UART `start`.
- `tx_data` out DATA_W: byte to UART `txin`; held stable until the next launch.
- `tx_done` in 1: UART `txdone`, a single-cycle pulse at frame end.

## Operation
- FIFO storage:
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is kept explicitly. `full = (count==DEPTH)`, `empty = (count==0)`.
- Writes:
  - A write with `wr_en=1` and `full=0` stores `wr_data` at the write pointer, advances the pointer and increments `count`.
  - A write while `full=1` is dropped and the FIFO is unchanged. `full` is judged on registered state, so a write is dropped even if a pop happens in the same cycle.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Sequencer states:
  - IDLE: if `empty=0`, pop the head into `tx_data`, set `tx_start=1` and go to WAIT. Otherwise stay in IDLE.
  - WAIT: `tx_start` returns to 0 after one cycle. On `tx_done=1`, go to IDLE. Otherwise stay in WAIT.
- `tx_done` is ignored in IDLE.
- A `tx_done` that coincides with the launch cycle is not counted; WAIT sees only pulses that arrive after entry.
- Reset: all values below apply asynchronously. Any queued bytes and any in-flight sequencing are discarded. A frame the UART has already started is not aborted by this block.
  - `count=0`, `empty=1`, `full=0`, `overflow=0`.
  - `tx_start=0`, `tx_data=0`.
  - Pointers 0, state IDLE.

## Timing
- Write to launch latency:
  - Write accepted at edge E: `empty` falls after E.
  - At edge E+1 the sequencer pops, `tx_data` updates and `tx_start` rises.
  - At edge E+2 `tx_start` falls.
- Back-to-back frames: `tx_done` sampled at edge D puts the sequencer in IDLE; the next pop and `tx_start` follow at edge D+1.
- `count` reflects push and pop at the same edge that performs them.
- No combinational path exists from any input to any output; all outputs are registered or decoded from registered state.

## Configuration
- Macro: `UART_TX_FIFO_OVF_EN`.
- Defined: `overflow` is set on any dropped write and stays set until `rst`.
- Undefined: the `overflow` port remains present and is tied to 0. Dropped writes are silent.

## Structure
- Shared package `uart_pkg`:
  - `DATA_W` default constant.
  - Sequencer state enum (IDLE, WAIT).
- One sub-module, `uart_sync_fifo`, holds the storage, pointers, `count`, `full` and `empty`. The sequencer and `overflow` logic live in `uart_tx_fifo`.
- The top-level integration wires `tx_start`→`start`, `tx_data`→`txin` and `txdone`→`tx_done` of `uart`. `tx` loops back to `rx` for self-check against `rxout`/`rxdone`.

## Test plan
- Single byte:
  - Stimulus: reset, then write 0xA5.
  - Response: `tx_start` pulses exactly one cycle, 2 edges after the write. `tx_data=0xA5`. With loopback, `rxout=0xA5` at `rxdone`. `empty=1` after the pop.
- Burst of 10:
  - Stimulus: write 10 random bytes in the range 10..200 on consecutive cycles.
  - Response: 10 `tx_start` pulses, each one cycle after the prior `tx_done`. Loopback `rxout` sequence equals the write order. `count` peaks at 9.
- Fill and overflow:
  - Stimulus: hold `tx_done=0` and write DEPTH+2 bytes.
  - Response: `full=1` with `count=DEPTH`. The first byte is in flight and the last byte is dropped. `overflow=1` only with `UART_TX_FIFO_OVF_EN` defined.
- Pointer wrap:
  - Stimulus: 40 bytes streamed with DEPTH=16, with overlapping push and pop.
  - Response: bytes are received in order and `count` never exceeds 16.
- Simultaneous push/pop:
  - Stimulus: with `count=3`, write in the pop cycle.
  - Response: `count` stays 3.
- Reset mid-frame:
  - Stimulus: assert `rst` in WAIT with `count=5`.
  - Response: `count=0`, `tx_start=0`, `tx_data=0`. No further launches until a new write.
